sr_flag_arbiter: RTL

- Shared bank of NFLAG set/reset flag bits with NREQ independent requesters.
- A round-robin arbiter grants one requester per active clock edge.
- The winner's 2-bit {s,r} command is applied to its addressed flag.
- Guarantees the bank never sees a simultaneous set+reset: the forbidden 11 code is trapped and reported, never stored as X.
- Used wherever several agents share status/semaphore flags built from SR flip-flops.

---
 rtl/sr_flag_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbitrated bank of SR flag bits; the illegal set+reset code is trapped and reported.
// Optional per-flag ownership locking is enabled by defining SR_FLAG_OWNER_LOCK_EN.
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int AW    = 3,
    parameter int IDW   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   cmd,
    input  logic [AW*NREQ-1:0]  addr,
    output logic [NREQ-1:0]     gnt,
    output logic [NFLAG-1:0]    flags,
    output logic                err,
    output logic [IDW-1:0]      err_id,
    output logic                busy
);

    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_CLR  = 2'b01,
        CMD_SET  = 2'b10,
        CMD_BAD  = 2'b11
    } sr_cmd_e;

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NFLAG-1:0] flags_q, flags_d;
    logic             err_q;
    logic [IDW-1:0]   err_id_q;

    logic             found;
    logic [IDW-1:0]   win;
    logic [1:0]       w_cmd;
    logic [AW-1:0]    w_addr;
    logic             addr_ok;
    logic             reject;
    int unsigned      idx;

`ifdef SR_FLAG_OWNER_LOCK_EN
    logic [IDW-1:0]   owner_q [NFLAG];
    logic [IDW-1:0]   owner_d [NFLAG];
`endif

    // Search starts at the round-robin pointer and wraps modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign w_cmd   = cmd[2*win +: 2];
    assign w_addr  = addr[AW*win +: AW];
    assign addr_ok = int'(w_addr) < NFLAG;
    assign ptr_d   = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;

    always_comb begin
        flags_d = flags_q;
        gnt_d   = '0;
        reject  = 1'b0;
`ifdef SR_FLAG_OWNER_LOCK_EN
        owner_d = owner_q;
`endif
        if (found) begin
            gnt_d[win] = 1'b1;
            if (!addr_ok || w_cmd == CMD_BAD) begin
                reject = 1'b1;
            end else begin
                case (sr_cmd_e'(w_cmd))
                    CMD_SET: begin
`ifdef SR_FLAG_OWNER_LOCK_EN
                        // A set flag belongs to whoever set it; only that owner may touch it.
                        if (!flags_q[w_addr]) begin
                            flags_d[w_addr] = 1'b1;
                            owner_d[w_addr] = win;
                        end else if (owner_q[w_addr] != win) begin
                            reject = 1'b1;
                        end
`else
                        flags_d[w_addr] = 1'b1;
`endif
                    end
                    CMD_CLR: begin
`ifdef SR_FLAG_OWNER_LOCK_EN
                        if (flags_q[w_addr] && owner_q[w_addr] != win) begin
                            reject = 1'b1;
                        end else begin
                            flags_d[w_addr] = 1'b0;
                        end
`else
                        flags_d[w_addr] = 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q    <= '0;
            gnt_q    <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            err_id_q <= '0;
`ifdef SR_FLAG_OWNER_LOCK_EN
            for (int i = 0; i < NFLAG; i++) owner_q[i] <= '0;
`endif
        end else begin
            gnt_q   <= gnt_d;
            flags_q <= flags_d;
            err_q   <= reject;
            if (found) ptr_q <= ptr_d;
            if (reject) err_id_q <= win;
`ifdef SR_FLAG_OWNER_LOCK_EN
            owner_q <= owner_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign flags  = flags_q;
    assign err    = err_q;
    assign err_id = err_id_q;
    assign busy   = |req;

endmodule
